// File: rtl/data_mem_subsystem_if.sv
// CPU MEM-stage bus into the data memory subsystem.
// The CPU side is the master; the cache is the slave.
interface data_mem_subsystem_if;
    logic [3:0]  memRead;
    logic [2:0]  memWrite;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSY_WAIT;

    modport master (
        output memRead, memWrite, ADDRESS, WRITE_DATA,
        input  READ_DATA, BUSY_WAIT
    );

    modport slave (
        input  memRead, memWrite, ADDRESS, WRITE_DATA,
        output READ_DATA, BUSY_WAIT
    );
endinterface

// File: rtl/data_mem_subsystem.sv
// Direct-mapped write-back/write-allocate data cache (8 x 128-bit lines)
// in front of a block-organised backing memory with fixed access latency.
module data_mem_subsystem #(
    parameter int MEM_LATENCY = 5,
    parameter int MEM_BLOCKS  = 64
) (
    input  logic CLK,
    input  logic RESET,
    data_mem_subsystem_if.slave bus
);
    localparam int MADDR_W = $clog2(MEM_BLOCKS);
    localparam int CNT_W   = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH, UPDATE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         valid_q, valid_d;
    logic [7:0]         dirty_q, dirty_d;
    logic [24:0]        tag_q  [8];
    logic [127:0]       line_q [8];
    logic [127:0]       mem_q  [MEM_BLOCKS];
    logic [127:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hold_q, hold_d;

    logic [24:0]        req_tag;
    logic [2:0]         req_index;
    logic [3:0]         req_off;
    logic               wr_req, rd_req, any_req, hit, busy;
    logic [127:0]       cur_line, merged, line_wdata;
    logic               line_we, tag_we, mem_we;
    logic               mem_rd, mem_wr, mem_done;
    logic [27:0]        victim_blk, fill_blk;
    logic [MADDR_W-1:0] mem_idx;
    logic [15:0]        wr_mask;
    logic [127:0]       wr_rep;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_word, ld_val;

    assign req_tag    = bus.ADDRESS[31:7];
    assign req_index  = bus.ADDRESS[6:4];
    assign req_off    = bus.ADDRESS[3:0];
    assign wr_req     = bus.memWrite[2];
    assign rd_req     = bus.memRead[3] && !wr_req;
    assign any_req    = wr_req || bus.memRead[3];
    assign cur_line   = line_q[req_index];
    assign hit        = valid_q[req_index] && (tag_q[req_index] == req_tag);

    assign mem_rd     = (state_q == FETCH);
    assign mem_wr     = (state_q == WRITE_BACK);
    assign victim_blk = {tag_q[req_index], req_index};
    assign fill_blk   = bus.ADDRESS[31:4];
    assign mem_idx    = MADDR_W'((mem_wr ? victim_blk : fill_blk) % 28'(MEM_BLOCKS));
    assign mem_done   = (mem_rd || mem_wr) && !hold_q && (cnt_q == CNT_W'(MEM_LATENCY - 1));

    // After a block write the memory keeps busy one extra cycle before it accepts the refill read.
    always_comb begin
        cnt_d   = '0;
        hold_d  = 1'b0;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        if ((mem_rd || mem_wr) && !hold_q && !mem_done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (mem_done) begin
            if (mem_wr) begin
                mem_we = 1'b1;
                hold_d = 1'b1;
            end else begin
                rdata_d = mem_q[mem_idx];
            end
        end
    end

    always_comb begin
        wr_mask = '0;
        wr_rep  = '0;
        merged  = cur_line;
        case (bus.memWrite[1:0])
            2'b00: begin
                wr_mask = 16'h0001 << req_off;
                wr_rep  = {16{bus.WRITE_DATA[7:0]}};
            end
            2'b01: begin
                wr_mask = 16'h0003 << {req_off[3:1], 1'b0};
                wr_rep  = {8{bus.WRITE_DATA[15:0]}};
            end
            default: begin
                wr_mask = 16'h000F << {req_off[3:2], 2'b00};
                wr_rep  = {4{bus.WRITE_DATA}};
            end
        endcase
        for (int k = 0; k < 16; k++) begin
            if (wr_mask[k]) begin
                merged[8*k +: 8] = wr_rep[8*k +: 8];
            end
        end
    end

    always_comb begin
        ld_byte = cur_line[{req_off, 3'b000} +: 8];
        ld_half = cur_line[{req_off[3:1], 4'b0000} +: 16];
        ld_word = cur_line[{req_off[3:2], 5'b00000} +: 32];
        ld_val  = '0;
        case (bus.memRead[2:0])
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_val = ld_word;
            3'b100:  ld_val = {24'h0, ld_byte};
            3'b101:  ld_val = {16'h0, ld_half};
            default: ld_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        line_we    = 1'b0;
        tag_we     = 1'b0;
        line_wdata = merged;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (hit) begin
                        if (wr_req) begin
                            line_we            = 1'b1;
                            dirty_d[req_index] = 1'b1;
                        end
                    end else if (valid_q[req_index] && dirty_q[req_index]) begin
                        state_d = WRITE_BACK;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            WRITE_BACK: if (mem_done) state_d = FETCH;
            FETCH:      if (mem_done) state_d = UPDATE;
            UPDATE: begin
                line_we            = 1'b1;
                tag_we             = 1'b1;
                line_wdata         = rdata_q;
                valid_d[req_index] = 1'b1;
                dirty_d[req_index] = 1'b0;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with RESET lets the stall drop the moment reset is asserted, even mid-miss.
    assign busy          = (state_q != IDLE) || (any_req && !hit);
    assign bus.BUSY_WAIT = RESET && busy;
    assign bus.READ_DATA = (state_q == IDLE && rd_req && hit) ? ld_val : 32'h0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < 8; i++) begin
                tag_q[i]  <= '0;
                line_q[i] <= '0;
            end
            for (int i = 0; i < MEM_BLOCKS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            rdata_q <= rdata_d;
            if (line_we) line_q[req_index] <= line_wdata;
            if (tag_we)  tag_q[req_index]  <= req_tag;
            if (mem_we)  mem_q[mem_idx]    <= cur_line;
        end
    end
endmodule

// File: tb/tb_data_mem_subsystem.sv
// Self-checking bench for data_mem_subsystem: directed test-plan steps followed by
// random loads/stores compared against a byte-array memory and line-residency model.
module tb_data_mem_subsystem;
    localparam int LAT         = 5;
    localparam int CLEAN_STALL = LAT + 2;
    localparam int DIRTY_STALL = 2 * LAT + 3;

    localparam logic [3:0] LB  = 4'b1000;
    localparam logic [3:0] LH  = 4'b1001;
    localparam logic [3:0] LW  = 4'b1010;
    localparam logic [3:0] LBU = 4'b1100;
    localparam logic [3:0] LHU = 4'b1101;
    localparam logic [2:0] SB  = 3'b100;
    localparam logic [2:0] SH  = 3'b101;
    localparam logic [2:0] SW  = 3'b110;
    localparam logic [3:0] NR  = 4'b0000;
    localparam logic [2:0] NW  = 3'b000;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    data_mem_subsystem_if bus();

    data_mem_subsystem #(.MEM_LATENCY(LAT), .MEM_BLOCKS(64)) dut (
        .CLK   (clk),
        .RESET (rstN),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: visible memory is 1024 bytes (64 blocks, aliasing modulo depth);
    // the cache model only tracks which block each line holds and whether it is dirty.
    logic [7:0]  refMem [1024];
    bit          mValid [8];
    bit          mDirty [8];
    logic [24:0] mTag   [8];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] rd, input logic [2:0] wr,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        bus.memRead    = rd;
        bus.memWrite   = wr;
        bus.ADDRESS    = addr;
        bus.WRITE_DATA = wdata;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 1024; i++) refMem[i] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
            mTag[i]   = '0;
        end
    endtask

    function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [2:0] f3);
        logic [9:0]  a;
        logic [7:0]  b;
        logic [15:0] h;
        a = addr[9:0];
        b = refMem[a];
        h = {refMem[{a[9:1], 1'b1}], refMem[{a[9:1], 1'b0}]};
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return {refMem[{a[9:2], 2'b11}], refMem[{a[9:2], 2'b10}],
                             refMem[{a[9:2], 2'b01}], refMem[{a[9:2], 2'b00}]};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void modelStore(input logic [31:0] addr, input logic [1:0] wf, input logic [31:0] d);
        logic [9:0] a;
        a = addr[9:0];
        case (wf)
            2'b00: refMem[a] = d[7:0];
            2'b01: begin
                refMem[{a[9:1], 1'b0}] = d[7:0];
                refMem[{a[9:1], 1'b1}] = d[15:8];
            end
            default: begin
                for (int k = 0; k < 4; k++) refMem[{a[9:2], 2'b00} + 10'(k)] = d[8*k +: 8];
            end
        endcase
    endfunction

    function automatic int modelStall(input logic [31:0] addr, input bit isWrite);
        int idx;
        int stall;
        bit hitNow;
        idx    = int'(addr[6:4]);
        hitNow = mValid[idx] && (mTag[idx] == addr[31:7]);
        stall  = hitNow ? 0 : ((mValid[idx] && mDirty[idx]) ? DIRTY_STALL : CLEAN_STALL);
        mDirty[idx] = (hitNow ? mDirty[idx] : 1'b0) | isWrite;
        mValid[idx] = 1'b1;
        mTag[idx]   = addr[31:7];
        return stall;
    endfunction

    // Called just after a rising edge; leaves the bus idle just after the completing edge.
    task automatic doAccess(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] expData);
        int expStall;
        int stalls;
        logic [31:0] rdata;
        expStall = modelStall(addr, wr[2]);
        applyStimulus(rd, wr, addr, wdata);
        @(negedge clk);
        stalls = 0;
        while (bus.BUSY_WAIT !== 1'b0 && stalls < 100) begin
            @(posedge clk);
            stalls++;
            @(negedge clk);
        end
        rdata = bus.READ_DATA;
        checkOutput({tag, "/stall"}, 32'(stalls), 32'(expStall));
        checkOutput({tag, "/data"}, rdata, expData);
        if (wr[2]) modelStore(addr, wr[1:0], wdata);
        @(posedge clk);
        #1;
        applyStimulus(NR, NW, addr, 32'h0);
    endtask

    logic [2:0]  loadF3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [1:0]  storeWf [3] = '{2'b00, 2'b01, 2'b10};
    logic [31:0] rAddr, rData, rExp;
    logic [2:0]  rF3;
    logic [1:0]  rWf;

    initial begin
        rstN = 1'b1;
        applyStimulus(NR, NW, 32'h0, 32'h0);
        modelReset();
        #1 rstN = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset/busyIdle", {31'b0, bus.BUSY_WAIT}, 32'h0);
        checkOutput("reset/dataIdle", bus.READ_DATA, 32'h0);
        applyStimulus(LW, NW, 32'h0, 32'h0);
        #1;
        checkOutput("reset/busyWithReq", {31'b0, bus.BUSY_WAIT}, 32'h0);
        applyStimulus(NR, NW, 32'h0, 32'h0);
        @(posedge clk);
        #1 rstN = 1'b1;

        $display("[TB] directed sequence");
        doAccess("firstLW",    LW,  NW, 32'h0000_0000, 32'h0,         32'h0000_0000);
        doAccess("SW_C",       NR,  SW, 32'h0000_000C, 32'hDEAD_BEEF, 32'h0);
        doAccess("LW_C",       LW,  NW, 32'h0000_000C, 32'h0,         32'hDEAD_BEEF);
        doAccess("LBU_F",      LBU, NW, 32'h0000_000F, 32'h0,         32'h0000_00DE);
        doAccess("LB_F",       LB,  NW, 32'h0000_000F, 32'h0,         32'hFFFF_FFDE);
        doAccess("LHU_C",      LHU, NW, 32'h0000_000C, 32'h0,         32'h0000_BEEF);
        doAccess("LH_C",       LH,  NW, 32'h0000_000C, 32'h0,         32'hFFFF_BEEF);
        doAccess("SB_D",       NR,  SB, 32'h0000_000D, 32'h0000_0055, 32'h0);
        doAccess("LW_merge",   LW,  NW, 32'h0000_000C, 32'h0,         32'hDEAD_55EF);
        doAccess("SW_10",      NR,  SW, 32'h0000_0010, 32'h1234_5678, 32'h0);
        doAccess("LW_90evict", LW,  NW, 32'h0000_0090, 32'h0,         32'h0000_0000);
        doAccess("LW_10back",  LW,  NW, 32'h0000_0010, 32'h0,         32'h1234_5678);
        doAccess("LHU_odd",    LHU, NW, 32'h0000_0013, 32'h0,         32'h0000_1234);
        doAccess("LW_unalign", LW,  NW, 32'h0000_0013, 32'h0,         32'h1234_5678);

        $display("[TB] mid-miss reset");
        applyStimulus(LW, NW, 32'h0000_0020, 32'h0);
        @(negedge clk);
        checkOutput("midmiss/busyReq", {31'b0, bus.BUSY_WAIT}, 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midmiss/busyInReset", {31'b0, bus.BUSY_WAIT}, 32'h0);
        modelReset();
        @(posedge clk);
        #1 rstN = 1'b1;
        doAccess("midmiss/refetch", LW, NW, 32'h0000_0020, 32'h0, 32'h0);
        doAccess("postReset/LW_C",  LW, NW, 32'h0000_000C, 32'h0, 32'h0);

        $display("[TB] simultaneous read and write");
        doAccess("simul/rdwr", LW, SW, 32'h0000_000C, 32'hCAFE_F00D, 32'h0);
        doAccess("simul/check", LW, NW, 32'h0000_000C, 32'h0, 32'hCAFE_F00D);

        $display("[TB] random accesses");
        for (int i = 0; i < 80; i++) begin
            rAddr = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) == 0) rAddr[31:12] = 20'hABCDE;
            rData = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                rF3  = loadF3[$urandom_range(0, 4)];
                rExp = modelLoad(rAddr, rF3);
                doAccess("rand/load", {1'b1, rF3}, NW, rAddr, 32'h0, rExp);
            end else begin
                rWf = storeWf[$urandom_range(0, 2)];
                doAccess("rand/store", NR, {1'b1, rWf}, rAddr, rData, 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
